// File: rtl/mc_control_fsm.sv
// Multicycle CPU control unit: registered state, combinational next state and per-state datapath strobes.
// Memory states stall on mem_ready with a bounded wait; HALT and ERROR are sticky until Reset.
module mc_control_fsm #(
   parameter int STATE_W  = 5,
   parameter int OPC_W    = 4,
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [OPC_W-1:0]   opcode,
   input  logic               zero_flag,
   input  logic               mem_ready,
   output logic [STATE_W-1:0] state,
   output logic [STATE_W-1:0] nextstate,
   output logic               ir_we,
   output logic               pc_we,
   output logic [1:0]         pc_src,
   output logic               reg_we,
   output logic               wb_src,
   output logic               mem_rd,
   output logic               mem_we,
   output logic [1:0]         addr_src,
   output logic               sp_inc,
   output logic               sp_dec,
   output logic               halted,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [CNT_W-1:0]   instr_cnt
);

   localparam int WCNT_W = $clog2(WAIT_MAX + 1);

   typedef enum logic [STATE_W-1:0] {
      FETCH    = 5'd0,
      DECODE   = 5'd1,
      EXEC_ALU = 5'd2,
      WB_ALU   = 5'd3,
      ADDR     = 5'd4,
      MEMRD    = 5'd5,
      WB_MEM   = 5'd6,
      MEMWR    = 5'd7,
      PUSH_DEC = 5'd8,
      PUSH_WR  = 5'd9,
      POP_RD   = 5'd10,
      POP_INC  = 5'd11,
      BR_EVAL  = 5'd12,
      CALL_DEC = 5'd13,
      CALL_WR  = 5'd14,
      CALL_JMP = 5'd15,
      RET_RD   = 5'd16,
      RET_INC  = 5'd17,
      HALT     = 5'd18,
      ERROR    = 5'd19
   } state_t;

   state_t             state_q;
   state_t             state_n;
   logic [WCNT_W-1:0]  wait_cnt;
   logic [OPC_W-1:0]   op_q;
   logic [1:0]         err_code_q;
   logic [1:0]         err_set;
   logic [CNT_W-1:0]   instr_cnt_q;
   logic               mem_st;
   logic               br_take;

   assign state     = state_q;
   assign nextstate = state_n;
   assign instr_cnt = instr_cnt_q;
   assign br_take   = (op_q == 4'h9) || zero_flag;

   always_comb begin
      state_n = state_q;
      err_set = 2'b00;
      mem_st  = 1'b0;
      case (state_q)
         FETCH: begin
            mem_st = 1'b1;
            if (mem_ready) state_n = DECODE;
         end
         DECODE: begin
            case (opcode)
               4'h0, 4'h1, 4'h2, 4'h3: state_n = EXEC_ALU;
               4'h4, 4'h5:             state_n = ADDR;
               4'h6:                   state_n = PUSH_DEC;
               4'h7:                   state_n = POP_RD;
               4'h8, 4'h9:             state_n = BR_EVAL;
               4'hA:                   state_n = CALL_DEC;
               4'hB:                   state_n = RET_RD;
               4'hF:                   state_n = HALT;
               default: begin
                  state_n = ERROR;
                  err_set = 2'b01;
               end
            endcase
         end
         EXEC_ALU: state_n = WB_ALU;
         WB_ALU:   state_n = FETCH;
         ADDR:     state_n = (op_q == 4'h4) ? MEMRD : MEMWR;
         MEMRD: begin
            mem_st = 1'b1;
            if (mem_ready) state_n = WB_MEM;
         end
         WB_MEM: state_n = FETCH;
         MEMWR: begin
            mem_st = 1'b1;
            if (mem_ready) state_n = FETCH;
         end
         PUSH_DEC: state_n = PUSH_WR;
         PUSH_WR: begin
            mem_st = 1'b1;
            if (mem_ready) state_n = FETCH;
         end
         POP_RD: begin
            mem_st = 1'b1;
            if (mem_ready) state_n = POP_INC;
         end
         POP_INC:  state_n = FETCH;
         BR_EVAL:  state_n = FETCH;
         CALL_DEC: state_n = CALL_WR;
         CALL_WR: begin
            mem_st = 1'b1;
            if (mem_ready) state_n = CALL_JMP;
         end
         CALL_JMP: state_n = FETCH;
         RET_RD: begin
            mem_st = 1'b1;
            if (mem_ready) state_n = RET_INC;
         end
         RET_INC: state_n = FETCH;
         HALT:    state_n = HALT;
         ERROR:   state_n = ERROR;
         default: begin
            state_n = ERROR;
            err_set = 2'b01;
         end
      endcase
      // The wait counter reaching WAIT_MAX gives one last look at mem_ready before timing out.
      if (mem_st && !mem_ready && (wait_cnt == WCNT_W'(WAIT_MAX))) begin
         state_n = ERROR;
         err_set = 2'b10;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= FETCH;
         wait_cnt    <= '0;
         op_q        <= '0;
         err_code_q  <= 2'b00;
         instr_cnt_q <= '0;
      end else begin
         state_q <= state_n;
         if (state_n != state_q)
            wait_cnt <= '0;
         else if (mem_st && !mem_ready)
            wait_cnt <= wait_cnt + WCNT_W'(1);
         if (state_q == DECODE)
            op_q <= opcode;
         if ((state_n == ERROR) && (state_q != ERROR))
            err_code_q <= err_set;
         if ((state_n == FETCH) && (state_q != FETCH))
            instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 2'd0;
      reg_we   = 1'b0;
      wb_src   = 1'b0;
      mem_rd   = 1'b0;
      mem_we   = 1'b0;
      addr_src = 2'd0;
      sp_inc   = 1'b0;
      sp_dec   = 1'b0;
      halted   = 1'b0;
      err      = 1'b0;
      err_code = 2'b00;
      case (state_q)
         FETCH: begin
            mem_rd = 1'b1;
            ir_we  = mem_ready;
            pc_we  = mem_ready;
         end
         WB_ALU: reg_we = 1'b1;
         MEMRD: begin
            mem_rd   = 1'b1;
            addr_src = 2'd1;
         end
         WB_MEM: begin
            reg_we = 1'b1;
            wb_src = 1'b1;
         end
         MEMWR: begin
            mem_we   = 1'b1;
            addr_src = 2'd1;
         end
         PUSH_DEC, CALL_DEC: sp_dec = 1'b1;
         PUSH_WR, CALL_WR: begin
            mem_we   = 1'b1;
            addr_src = 2'd2;
         end
         POP_RD, RET_RD: begin
            mem_rd   = 1'b1;
            addr_src = 2'd2;
         end
         POP_INC: begin
            sp_inc = 1'b1;
            reg_we = 1'b1;
            wb_src = 1'b1;
         end
         BR_EVAL: begin
            if (br_take) begin
               pc_we  = 1'b1;
               pc_src = 2'd1;
            end
         end
         CALL_JMP: begin
            pc_we  = 1'b1;
            pc_src = 2'd1;
         end
         RET_INC: begin
            sp_inc = 1'b1;
            pc_we  = 1'b1;
            pc_src = 2'd2;
         end
         HALT: halted = 1'b1;
         ERROR: begin
            err      = 1'b1;
            err_code = err_code_q;
         end
         default: ;
      endcase
      // Reset must kill every request at once, including FETCH's mem_rd.
      if (Reset) begin
         ir_we    = 1'b0;
         pc_we    = 1'b0;
         pc_src   = 2'd0;
         reg_we   = 1'b0;
         wb_src   = 1'b0;
         mem_rd   = 1'b0;
         mem_we   = 1'b0;
         addr_src = 2'd0;
         sp_inc   = 1'b0;
         sp_dec   = 1'b0;
         halted   = 1'b0;
         err      = 1'b0;
         err_code = 2'b00;
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level reference paths with random stalls and operands.
// A second instance with a 4-bit counter exercises instruction-counter wraparound.
module tb_mc_control_fsm;
   localparam int WAIT_MAX = 15;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [3:0]  opcode = 4'h0;
   logic        zero_flag = 1'b0;
   logic        mem_ready = 1'b0;

   logic [4:0]  state, nextstate, w_state, w_nextstate;
   logic        ir_we, pc_we, reg_we, wb_src, mem_rd, mem_we, sp_inc, sp_dec, halted, err;
   logic [1:0]  pc_src, addr_src, err_code;
   logic [15:0] instr_cnt;
   logic        w_ir_we, w_pc_we, w_reg_we, w_wb_src, w_mem_rd, w_mem_we, w_sp_inc, w_sp_dec;
   logic        w_halted, w_err;
   logic [1:0]  w_pc_src, w_addr_src, w_err_code;
   logic [3:0]  w_instr_cnt;

   mc_control_fsm dut (
      .Clk(Clk), .Reset(Reset), .opcode(opcode), .zero_flag(zero_flag), .mem_ready(mem_ready),
      .state(state), .nextstate(nextstate), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .reg_we(reg_we), .wb_src(wb_src), .mem_rd(mem_rd), .mem_we(mem_we), .addr_src(addr_src),
      .sp_inc(sp_inc), .sp_dec(sp_dec), .halted(halted), .err(err), .err_code(err_code),
      .instr_cnt(instr_cnt)
   );

   mc_control_fsm #(.CNT_W(4)) dut_w (
      .Clk(Clk), .Reset(Reset), .opcode(opcode), .zero_flag(zero_flag), .mem_ready(mem_ready),
      .state(w_state), .nextstate(w_nextstate), .ir_we(w_ir_we), .pc_we(w_pc_we),
      .pc_src(w_pc_src), .reg_we(w_reg_we), .wb_src(w_wb_src), .mem_rd(w_mem_rd),
      .mem_we(w_mem_we), .addr_src(w_addr_src), .sp_inc(w_sp_inc), .sp_dec(w_sp_dec),
      .halted(w_halted), .err(w_err), .err_code(w_err_code), .instr_cnt(w_instr_cnt)
   );

   wire [15:0] obs_v = {ir_we, pc_we, pc_src, reg_we, wb_src, mem_rd, mem_we, addr_src,
                        sp_inc, sp_dec, halted, err, err_code};
   wire [15:0] w_obs_v = {w_ir_we, w_pc_we, w_pc_src, w_reg_we, w_wb_src, w_mem_rd, w_mem_we,
                          w_addr_src, w_sp_inc, w_sp_dec, w_halted, w_err, w_err_code};

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   int exp_retired = 0;
   logic [1:0] exp_code = 2'b00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Strobe table: what each state must drive, given ready, zero flag and the instruction's opcode.
   function automatic logic [15:0] exp_out(input int st, input logic rdy, input logic zf,
                                           input logic [3:0] op);
      logic iw, pw, rw, ws, mr, mw, si, sd, h, e;
      logic [1:0] ps, as, ec;
      {iw, pw, rw, ws, mr, mw, si, sd, h, e} = '0;
      ps = 2'd0; as = 2'd0; ec = 2'd0;
      case (st)
         0:  begin mr = 1; iw = rdy; pw = rdy; end
         3:  rw = 1;
         5:  begin mr = 1; as = 2'd1; end
         6:  begin rw = 1; ws = 1; end
         7:  begin mw = 1; as = 2'd1; end
         8:  sd = 1;
         9:  begin mw = 1; as = 2'd2; end
         10: begin mr = 1; as = 2'd2; end
         11: begin si = 1; rw = 1; ws = 1; end
         12: if (op == 4'h9 || zf) begin pw = 1; ps = 2'd1; end
         13: sd = 1;
         14: begin mw = 1; as = 2'd2; end
         15: begin pw = 1; ps = 2'd1; end
         16: begin mr = 1; as = 2'd2; end
         17: begin si = 1; pw = 1; ps = 2'd2; end
         18: h = 1;
         19: begin e = 1; ec = exp_code; end
         default: ;
      endcase
      return {iw, pw, ps, rw, ws, mr, mw, as, si, sd, h, e, ec};
   endfunction

   function automatic bit is_mem(input int st);
      return st == 0 || st == 5 || st == 7 || st == 9 || st == 10 || st == 14 || st == 16;
   endfunction

   // Called at posedge+1; drives inputs, samples mid-cycle, then advances one clock.
   task automatic do_cycle(input int st, input int nxt, input logic rdy, input logic [3:0] op_drv,
                           input logic zf_drv, input logic [3:0] op_i);
      logic [15:0] e;
      mem_ready = rdy; opcode = op_drv; zero_flag = zf_drv;
      #2;
      e = exp_out(st, rdy, zf_drv, op_i);
      check("state", state, st);
      check("nextstate", nextstate, nxt);
      check("strobes", obs_v, e);
      check("instr_cnt", instr_cnt, exp_retired & 32'hFFFF);
      check("state_w", w_state, st);
      check("strobes_w", w_obs_v, e);
      check("instr_cnt_w", w_instr_cnt, exp_retired & 32'hF);
      @(posedge Clk); #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1; mem_ready = 1'(  $urandom);
      #2;
      check("rst_state", state, 0);
      check("rst_strobes", obs_v, 0);
      check("rst_cnt", instr_cnt, 0);
      @(posedge Clk); #1;
      check("rst_strobes_hold", obs_v, 0);
      Reset = 1'b0;
      exp_retired = 0;
   endtask

   task automatic run_instr(input logic [3:0] op, input logic zf, input int smin, input int smax);
      int path[$];
      int st, nxt, s;
      bit terminal, timed_out;
      logic [3:0] od;
      logic zd;
      path = {0, 1};
      terminal = 0; timed_out = 0;
      case (op)
         4'h0, 4'h1, 4'h2, 4'h3: path = {path, 2, 3};
         4'h4: path = {path, 4, 5, 6};
         4'h5: path = {path, 4, 7};
         4'h6: path = {path, 8, 9};
         4'h7: path = {path, 10, 11};
         4'h8, 4'h9: path = {path, 12};
         4'hA: path = {path, 13, 14, 15};
         4'hB: path = {path, 16, 17};
         4'hF: begin path.push_back(18); terminal = 1; end
         default: begin path.push_back(19); terminal = 1; exp_code = 2'b01; end
      endcase
      for (int i = 0; i < path.size(); i++) begin
         st  = path[i];
         od  = (st == 1) ? op : 4'($urandom);
         zd  = (st == 12) ? zf : 1'($urandom);
         nxt = (i + 1 < path.size()) ? path[i+1] : (terminal ? st : 0);
         if (is_mem(st)) begin
            s = $urandom_range(smax, smin);
            if (s > WAIT_MAX) begin
               for (int k = 0; k <= WAIT_MAX; k++)
                  do_cycle(st, (k == WAIT_MAX) ? 19 : st, 1'b0, od, zd, op);
               exp_code = 2'b10;
               timed_out = 1;
               break;
            end
            for (int k = 0; k < s; k++) do_cycle(st, st, 1'b0, od, zd, op);
            do_cycle(st, nxt, 1'b1, od, zd, op);
         end else begin
            do_cycle(st, nxt, 1'($urandom), od, zd, op);
         end
      end
      if (timed_out || terminal) begin
         st = timed_out ? 19 : path[path.size()-1];
         for (int k = 0; k < 4; k++)
            do_cycle(st, st, 1'($urandom), 4'($urandom), 1'($urandom), op);
      end else begin
         exp_retired++;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; mem_ready = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      check("init_state", state, 0);
      check("init_strobes", obs_v, 0);
      check("init_cnt", instr_cnt, 0);
      Reset = 1'b0;

      run_instr(4'h0, 1'b0, 0, 0);
      run_instr(4'h4, 1'b0, 3, 3);
      run_instr(4'h8, 1'b0, 0, 1);
      run_instr(4'h8, 1'b1, 0, 1);
      run_instr(4'h9, 1'b0, 0, 1);
      run_instr(4'hA, 1'b0, 0, 2);
      run_instr(4'hB, 1'b0, 0, 2);
      run_instr(4'h5, 1'b0, WAIT_MAX, WAIT_MAX);
      run_instr(4'h6, 1'b1, 0, 2);
      run_instr(4'h7, 1'b0, 0, 2);
      for (int n = 0; n < 40; n++)
         run_instr(4'($urandom_range(11, 0)), 1'($urandom), 0, 3);

      do_reset();
      do_cycle(0, 1, 1'b1, 4'($urandom), 1'($urandom), 4'h5);
      do_cycle(1, 4, 1'($urandom), 4'h5, 1'($urandom), 4'h5);
      do_cycle(4, 7, 1'($urandom), 4'($urandom), 1'($urandom), 4'h5);
      mem_ready = 1'b0;
      #2;
      check("memwr_mem_we", mem_we, 1);
      Reset = 1'b1;
      #1;
      check("async_rst_state", state, 0);
      check("async_rst_mem_we", mem_we, 0);
      check("async_rst_strobes", obs_v, 0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      exp_retired = 0;

      run_instr(4'h1, 1'b0, 0, 1);
      run_instr(4'hC, 1'b0, 0, 1);
      do_reset();
      run_instr(4'h0, 1'b0, WAIT_MAX + 1, WAIT_MAX + 1);
      do_reset();
      run_instr(4'hF, 1'b0, 0, 1);
      do_reset();
      for (int n = 0; n < 30; n++) begin
         logic [3:0] op;
         op = 4'($urandom_range(15, 0));
         run_instr(op, 1'($urandom), 0, ($urandom_range(7, 0) == 0) ? WAIT_MAX + 1 : 3);
         if (state == 5'd18 || state == 5'd19) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
